// File: rtl/sudoku_game_ctrl_if.sv
// Bundle of user, datapath and display signals for the Sudoku game controller.
// master: the side that drives user entry and datapath results (user logic or bench).
// slave : the controller itself.
interface sudoku_game_ctrl_if #(
    parameter int IDX_W   = 4,
    parameter int MOVE_W  = 8,
    parameter int WRONG_W = 2
);
    // user entry
    logic               restart;
    logic               enter;
    logic               back;
    logic [IDX_W-1:0]   digit_in;
    // datapath check result: cell_ok and solved are only meaningful in the
    // cycle check_done is high; check_flag high means a check is outstanding.
    logic               check_done;
    logic               cell_ok;
    logic               solved;
    // controller outputs
    logic [3:0]         state;
    logic               gen_rand_flag;
    logic               set_board_flag;
    logic               set_diff_flag;
    logic               row_flag;
    logic               col_flag;
    logic               val_flag;
    logic               check_flag;
    logic [IDX_W-1:0]   sel_row;
    logic [IDX_W-1:0]   sel_col;
    logic [IDX_W-1:0]   sel_val;
    logic [MOVE_W-1:0]  move_cnt;
    logic [WRONG_W-1:0] wrong_cnt;
    logic               range_err;

    modport master (
        output restart, enter, back, digit_in, check_done, cell_ok, solved,
        input  state, gen_rand_flag, set_board_flag, set_diff_flag, row_flag,
               col_flag, val_flag, check_flag, sel_row, sel_col, sel_val,
               move_cnt, wrong_cnt, range_err
    );

    modport slave (
        input  restart, enter, back, digit_in, check_done, cell_ok, solved,
        output state, gen_rand_flag, set_board_flag, set_diff_flag, row_flag,
               col_flag, val_flag, check_flag, sel_row, sel_col, sel_val,
               move_cnt, wrong_cnt, range_err
    );
endinterface

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game controller: board setup, row/col/value entry with range
// checking, move check with timeout, move/mistake counters, WIN and LOSE.
// Optional macro SUDOKU_BACK_EN: 'back' steps from CHOOSE_COL to CHOOSE_ROW
// and from CHOOSE_VAL to CHOOSE_COL; without it the back input is ignored.
module sudoku_game_ctrl #(
    parameter int GRID_N    = 9,
    parameter int IDX_W     = 4,
    parameter int MAX_WRONG = 3,
    parameter int MOVE_W    = 8,
    parameter int CHECK_TO  = 16
) (
    input  logic              clka,
    input  logic              restart_n,
    sudoku_game_ctrl_if.slave bus
);
    localparam int WRONG_W = $clog2(MAX_WRONG + 1);
    localparam int TMR_W   = (CHECK_TO > 1) ? $clog2(CHECK_TO) : 1;

    localparam logic [IDX_W-1:0]   GRID_MAX  = IDX_W'(GRID_N);
    localparam logic [WRONG_W-1:0] WRONG_MAX = WRONG_W'(MAX_WRONG);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(CHECK_TO - 1);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SET_BOARD  = 4'd2,
        ST_SET_DIFF   = 4'd3,
        ST_CHOOSE_ROW = 4'd4,
        ST_CHOOSE_COL = 4'd5,
        ST_CHOOSE_VAL = 4'd6,
        ST_CHECKING   = 4'd7,
        ST_WRONG      = 4'd8,
        ST_WIN        = 4'd9,
        ST_LOSE       = 4'd10
    } state_t;

    // Flag order: {gen_rand, set_board, set_diff, row, col, val, check}
    function automatic logic [6:0] flags_for(state_t s);
        case (s)
            ST_IDLE:       return 7'b100_0000;
            ST_SET_BOARD:  return 7'b010_0000;
            ST_SET_DIFF:   return 7'b001_0000;
            ST_CHOOSE_ROW: return 7'b000_1000;
            ST_CHOOSE_COL: return 7'b000_0100;
            ST_CHOOSE_VAL: return 7'b000_0010;
            ST_CHECKING:   return 7'b000_0001;
            default:       return 7'b000_0000;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [6:0]         flags_q, flags_d;
    logic [IDX_W-1:0]   sel_row_q, sel_row_d;
    logic [IDX_W-1:0]   sel_col_q, sel_col_d;
    logic [IDX_W-1:0]   sel_val_q, sel_val_d;
    logic [MOVE_W-1:0]  move_cnt_q, move_cnt_d;
    logic [WRONG_W-1:0] wrong_cnt_q, wrong_cnt_d;
    logic               range_err_q, range_err_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               enter_q, enter_d;
    logic               ep;
    logic               back_hit;

    assign ep = bus.enter & ~enter_q;

    // State, selections, counters and flags registered together.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q     <= ST_IDLE;
            flags_q     <= 7'b100_0000;
            sel_row_q   <= '0;
            sel_col_q   <= '0;
            sel_val_q   <= '0;
            move_cnt_q  <= '0;
            wrong_cnt_q <= '0;
            range_err_q <= 1'b0;
            timer_q     <= '0;
            enter_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            sel_row_q   <= sel_row_d;
            sel_col_q   <= sel_col_d;
            sel_val_q   <= sel_val_d;
            move_cnt_q  <= move_cnt_d;
            wrong_cnt_q <= wrong_cnt_d;
            range_err_q <= range_err_d;
            timer_q     <= timer_d;
            enter_q     <= enter_d;
        end
    end

    // Next-state and datapath updates; soft restart overrides everything.
    always_comb begin
        state_d     = state_q;
        sel_row_d   = sel_row_q;
        sel_col_d   = sel_col_q;
        sel_val_d   = sel_val_q;
        move_cnt_d  = move_cnt_q;
        wrong_cnt_d = wrong_cnt_q;
        range_err_d = 1'b0;
        timer_d     = timer_q;
        enter_d     = bus.enter;
        back_hit    = 1'b0;
`ifdef SUDOKU_BACK_EN
        back_hit    = bus.back;
`endif
        if (bus.restart) begin
            state_d     = ST_IDLE;
            sel_row_d   = '0;
            sel_col_d   = '0;
            sel_val_d   = '0;
            move_cnt_d  = '0;
            wrong_cnt_d = '0;
            timer_d     = '0;
            enter_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:      if (ep) state_d = ST_SET_BOARD;
                ST_SET_BOARD: if (ep) state_d = ST_SET_DIFF;
                ST_SET_DIFF:  if (ep) state_d = ST_CHOOSE_ROW;
                ST_CHOOSE_ROW: begin
                    if (ep) begin
                        if (bus.digit_in < GRID_MAX) begin
                            sel_row_d = bus.digit_in;
                            state_d   = ST_CHOOSE_COL;
                        end else begin
                            range_err_d = 1'b1;
                        end
                    end
                end
                ST_CHOOSE_COL: begin
                    if (back_hit) begin
                        state_d = ST_CHOOSE_ROW;
                    end else if (ep) begin
                        if (bus.digit_in < GRID_MAX) begin
                            sel_col_d = bus.digit_in;
                            state_d   = ST_CHOOSE_VAL;
                        end else begin
                            range_err_d = 1'b1;
                        end
                    end
                end
                ST_CHOOSE_VAL: begin
                    if (back_hit) begin
                        state_d = ST_CHOOSE_COL;
                    end else if (ep) begin
                        if ((bus.digit_in != '0) && (bus.digit_in <= GRID_MAX)) begin
                            sel_val_d = bus.digit_in;
                            timer_d   = '0;
                            state_d   = ST_CHECKING;
                        end else begin
                            range_err_d = 1'b1;
                        end
                    end
                end
                ST_CHECKING: begin
                    if (bus.check_done) begin
                        if (bus.solved || bus.cell_ok) begin
                            if (!(&move_cnt_q)) move_cnt_d = move_cnt_q + 1'b1;
                            state_d = bus.solved ? ST_WIN : ST_CHOOSE_ROW;
                        end else begin
                            if (wrong_cnt_q != WRONG_MAX) wrong_cnt_d = wrong_cnt_q + 1'b1;
                            state_d = ST_WRONG;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        if (wrong_cnt_q != WRONG_MAX) wrong_cnt_d = wrong_cnt_q + 1'b1;
                        state_d = ST_WRONG;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                // wrong_cnt already holds the new count while in WRONG
                ST_WRONG: state_d = (wrong_cnt_q == WRONG_MAX) ? ST_LOSE : ST_CHOOSE_ROW;
                ST_WIN:   state_d = ST_WIN;
                ST_LOSE:  state_d = ST_LOSE;
                default:  state_d = ST_IDLE;
            endcase
        end
        flags_d = flags_for(state_d);
    end

    assign bus.state          = state_q;
    assign bus.gen_rand_flag  = flags_q[6];
    assign bus.set_board_flag = flags_q[5];
    assign bus.set_diff_flag  = flags_q[4];
    assign bus.row_flag       = flags_q[3];
    assign bus.col_flag       = flags_q[2];
    assign bus.val_flag       = flags_q[1];
    assign bus.check_flag     = flags_q[0];
    assign bus.sel_row        = sel_row_q;
    assign bus.sel_col        = sel_col_q;
    assign bus.sel_val        = sel_val_q;
    assign bus.move_cnt       = move_cnt_q;
    assign bus.wrong_cnt      = wrong_cnt_q;
    assign bus.range_err      = range_err_q;
endmodule

// File: doc/sudoku_game_ctrl.md
Name: sudoku_game_ctrl

Overview:
Parametrised single-clock successor to the two-phase Sudoku main controller. Sequences the game from board setup through row/column/value entry and move checking, ending in win or loss. Adds on-chip enter edge detection, range checking, latched selections, a check handshake with timeout, move and mistake counters, and a LOSE state. Drives the same flag set into the Sudoku datapath; state is exported to the user display.

Parameters:
GRID_N, 9, board dimension; legal row/col 0..GRID_N-1, legal value 1..GRID_N
IDX_W, 4, width of digit_in and sel_* (must satisfy 2^IDX_W > GRID_N)
MAX_WRONG, 3, wrong moves allowed before LOSE (>=1)
MOVE_W, 8, width of move_cnt
CHECK_TO, 16, cycles in CHECKING without check_done before the move is forced WRONG

Ports:
clka  in  1  sole clock, rising edge
restart_n  in  1  asynchronous active-low reset
restart  in  1  synchronous soft restart to IDLE
enter  in  1  user enter, level; edge-detected internally
back  in  1  step back one selection (SUDOKU_BACK_EN only)
digit_in  in  IDX_W  user row/col/value entry
check_done  in  1  datapath finished checking the move
cell_ok  in  1  move legal; valid with check_done
solved  in  1  board solved; valid with check_done
state  out  4  current state code
gen_rand_flag, set_board_flag, set_diff_flag, row_flag, col_flag, val_flag, check_flag  out  1 each  datapath phase flags
sel_row, sel_col, sel_val  out  IDX_W each  latched selections
move_cnt  out  MOVE_W  accepted correct moves
wrong_cnt  out  2  wrong moves so far (width clog2(MAX_WRONG+1); 2 at default)
range_err  out  1  one-cycle pulse: out-of-range entry rejected

Behaviour:
- States and codes: IDLE 0, SET_BOARD 2, SET_DIFF 3, CHOOSE_ROW 4, CHOOSE_COL 5, CHOOSE_VAL 6, CHECKING 7, WRONG 8, WIN 9, LOSE 10.
- Async reset (restart_n low): state=IDLE, gen_rand_flag=1, all other flags 0, sel_*=0, counters 0, range_err=0, enter history 0.
- Soft restart: same values on the next edge. Highest priority over enter, back and check_done.
- ep (enter pulse) = enter & ~enter_q, where enter_q is the previous sample. A held enter advances exactly one state.
- All outputs are registered. State and flags change together after the edge at which ep is seen; latency is 1 edge.
- Transitions on ep: IDLE->SET_BOARD->SET_DIFF->CHOOSE_ROW.
- CHOOSE_ROW on ep:
  - digit_in < GRID_N: latch sel_row, go to CHOOSE_COL.
  - otherwise: stay, pulse range_err.
- CHOOSE_COL: same rule as CHOOSE_ROW; latches sel_col, goes to CHOOSE_VAL.
- CHOOSE_VAL on ep:
  - 1 <= digit_in <= GRID_N: latch sel_val, go to CHECKING.
  - otherwise: stay, pulse range_err.
- CHECKING: timer clears on entry.
  - check_done & solved: go to WIN, move_cnt+1.
  - check_done & cell_ok & ~solved: go to CHOOSE_ROW, move_cnt+1.
  - check_done & ~cell_ok & ~solved: go to WRONG.
  - Timer reaches CHECK_TO-1 without check_done: go to WRONG.
  - ep is ignored.
- WRONG: one cycle; wrong_cnt+1. Then LOSE if the new wrong_cnt == MAX_WRONG, else CHOOSE_ROW.
- WIN and LOSE: hold until restart or reset; enter is ignored.
- move_cnt saturates at all-ones. wrong_cnt never exceeds MAX_WRONG.
- Flags are one-hot:
  - gen_rand_flag in IDLE; set_board_flag in SET_BOARD; set_diff_flag in SET_DIFF.
  - row_flag in CHOOSE_ROW; col_flag in CHOOSE_COL; val_flag in CHOOSE_VAL.
  - check_flag in CHECKING only.
  - All flags 0 in WRONG, WIN and LOSE.
- Illegal state codes recover to IDLE on the next edge, with IDLE outputs.

Optional Feature:
SUDOKU_BACK_EN
- Defined: back sampled high in CHOOSE_COL goes to CHOOSE_ROW; in CHOOSE_VAL goes to CHOOSE_COL. Latched selections are kept. back beats ep in the same cycle; back is ignored in all other states.
- Undefined: the back port still exists but is ignored; no back logic is synthesised.

Test Plan:
- Reset mid-game (in CHOOSE_VAL, move_cnt=5): drive restart_n low -> state=0 immediately, gen_rand_flag=1, move_cnt=0, sel_*=0.
- Enter held high for 10 cycles from IDLE -> one transition only, to state 2 with set_board_flag=1.
- Full correct move, GRID_N=9: enter row 3, col 7, val 5, then check_done=1, cell_ok=1 -> sel_row=3, sel_col=7, sel_val=5, check_flag=1 in state 7, then state=4 and move_cnt=1.
- Range checks: digit_in=9 in CHOOSE_ROW -> range_err one cycle, state stays 4. digit_in=0 in CHOOSE_VAL -> range_err, state stays 6.
- Three wrong moves (cell_ok=0), or one check left without check_done for 16 cycles -> WRONG each time, wrong_cnt 1,2,3, then state=10 (LOSE) with all flags 0; enter ignored; restart -> state 0.
- SUDOKU_BACK_EN defined: back and enter together in CHOOSE_VAL -> state 5, sel_col unchanged. Macro undefined: same stimulus -> state 7.
